// File: rtl/byte_word_packer.sv
// Byte-stream sink: packs bytes little-endian into words, buffers them in a small
// FIFO and presents them on a valid/ready port with partial flush and sticky overflow.
module byte_word_packer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            valid,
  input  logic [7:0]                      a,
  input  logic                            flush,
  input  logic                            ovf_clr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [8*WORD_BYTES-1:0]         out_data,
  output logic [$clog2(WORD_BYTES):0]     out_bytes,
  output logic [$clog2(DEPTH):0]          fifo_count,
  output logic                            overflow
);

  localparam int unsigned IW = $clog2(WORD_BYTES) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = 8 * WORD_BYTES;

  logic [WW-1:0] asm_word;
  logic [WW-1:0] asm_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_post;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  logic [WW-1:0] mem_data  [DEPTH];
  logic [IW-1:0] mem_bytes [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // Flush looks at the index after this edge's byte, so a completing byte
  // and a flush on the same edge yield a single full-word push.
  always_comb begin
    asm_next = asm_word;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (valid && idx == IW'(i)) asm_next[8*i +: 8] = a;
    end
    idx_post = idx + IW'(valid);
    push     = 1'b0;
    if (idx_post == IW'(WORD_BYTES))       push = 1'b1;
    else if (flush && idx_post != '0)      push = 1'b1;
    pop    = (count != '0) && out_ready;
    accept = push && ((count != CW'(DEPTH)) || pop);
    drop   = push && !accept;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_word <= '0;
      idx      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        asm_word <= '0;
        idx      <= '0;
      end else begin
        asm_word <= asm_next;
        idx      <= idx_post;
      end
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_data[wr_ptr]  <= asm_next;
      mem_bytes[wr_ptr] <= idx_post;
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr]  : '0;
  assign out_bytes  = out_valid ? mem_bytes[rd_ptr] : '0;
  assign fifo_count = count;

endmodule
